// File: rtl/mh_acceptance_unit.sv
// mh_acceptance_unit: Metropolis-Hastings accept/reject stage (ports: valid/ready energy pair in, rnd_enable/rnd sample handshake, done/accept out; MH_ACCEPT_STATS_EN adds accept/reject counters)
module mh_acceptance_unit #(
  parameter int ENERGY_WIDTH = 8,
  parameter int RND_WIDTH = 8,
  parameter int TEMP_SHIFT = 0,
  parameter int MAX_RETRY = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_valid,
  output logic                    out_ready,
  input  logic [ENERGY_WIDTH-1:0] in_energy_cur,
  input  logic [ENERGY_WIDTH-1:0] in_energy_prop,
  output logic                    out_rnd_enable,
  input  logic [RND_WIDTH-1:0]    in_rnd,
  output logic                    out_done,
  output logic                    out_accept
`ifdef MH_ACCEPT_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0]  out_accept_count,
  output logic [COUNT_WIDTH-1:0]  out_reject_count
`endif
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [RW-1:0] retry, retry_n;
  logic [7:0] thresh, thresh_n, t;
  logic accept_n, de_pos, rnd_neg;
  logic signed [ENERGY_WIDTH:0] de;
  logic [ENERGY_WIDTH:0] k;
  assign de = $signed({1'b0, in_energy_prop}) - $signed({1'b0, in_energy_cur});
  assign de_pos = !de[ENERGY_WIDTH] && (de != '0);
  assign k = $unsigned(de) >> TEMP_SHIFT;
  assign t = (k >= (ENERGY_WIDTH + 1)'(8)) ? 8'd0 : 8'd128 >> k[2:0];
  assign rnd_neg = in_rnd[RND_WIDTH-1];
  assign out_ready = (state == IDLE) && !in_reset;
  assign out_rnd_enable = state == REQ;
  assign out_done = state == DONE;
  always_comb begin
    state_n = state;
    retry_n = retry;
    thresh_n = thresh;
    accept_n = out_accept;
    case (state)
      IDLE: if (in_valid && out_ready) begin
        thresh_n = t;
        state_n = de_pos ? REQ : DONE;
        accept_n = de_pos ? out_accept : 1'b1;
      end
      REQ: state_n = WAIT;
      WAIT: if (rnd_neg && retry < RW'(MAX_RETRY)) begin
        retry_n = retry + 1'b1;
        state_n = REQ;
      end else begin
        accept_n = !rnd_neg && ({1'b0, in_rnd[6:0]} < thresh);
        state_n = DONE;
      end
      DONE: begin
        retry_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state <= IDLE;
      retry <= '0;
      thresh <= '0;
      out_accept <= 1'b0;
    end else begin
      state <= state_n;
      retry <= retry_n;
      thresh <= thresh_n;
      out_accept <= accept_n;
    end
  end
`ifdef MH_ACCEPT_STATS_EN
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      out_accept_count <= '0;
      out_reject_count <= '0;
    end else if (out_done) begin
      if (out_accept && out_accept_count != '1) out_accept_count <= out_accept_count + 1'b1;
      if (!out_accept && out_reject_count != '1) out_reject_count <= out_reject_count + 1'b1;
    end
  end
`endif
endmodule
